// File: rtl/spell_sram_arbiter_pkg.sv
// Shared types for the SPELL SRAM arbiter.
// Contents:
//   arb_state_e : arbiter FSM state encoding (idle, CPU granted, host granted)
//   req_id_e    : requester identity, used for the round-robin last-grant record
//   widths      : Wishbone address/data/select widths and the wait-counter width
package spell_sram_arbiter_pkg;

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 32;
  localparam int unsigned SelW  = 4;
  localparam int unsigned WaitW = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGntCpu  = 2'd1,
    StGntHost = 2'd2
  } arb_state_e;

  typedef enum logic {
    ReqCpu  = 1'b0,
    ReqHost = 1'b1
  } req_id_e;

endpackage

// File: rtl/spell_sram_arbiter.sv
// Two-port Wishbone arbiter sharing one OpenRAM SRAM between the CPU and a host
// (loader/debug) port. One transaction per grant, round-robin on contention,
// with a forced release if the SRAM stalls for TIMEOUT_CYCLES granted cycles.
// Ports:
//   clock, reset            : single clock, asynchronous active-high reset
//   cpu_*_i / cpu_ack_o     : CPU Wishbone request and acknowledge
//   host_*_i / host_ack_o   : host Wishbone request and acknowledge
//   rd_dat_o                : SRAM read data, shared by both requesters
//   sram_*_o / sram_*_i     : shared SRAM Wishbone port
//   timeout_o               : sticky flag, set by any forced release
module spell_sram_arbiter
  import spell_sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_cyc_i,
  input  logic             cpu_stb_i,
  input  logic             cpu_we_i,
  input  logic [SelW-1:0]  cpu_sel_i,
  input  logic [AddrW-1:0] cpu_addr_i,
  input  logic [DataW-1:0] cpu_dat_i,
  output logic             cpu_ack_o,
  input  logic             host_cyc_i,
  input  logic             host_stb_i,
  input  logic             host_we_i,
  input  logic [SelW-1:0]  host_sel_i,
  input  logic [AddrW-1:0] host_addr_i,
  input  logic [DataW-1:0] host_dat_i,
  output logic             host_ack_o,
  output logic [DataW-1:0] rd_dat_o,
  output logic             sram_cyc_o,
  output logic             sram_stb_o,
  output logic             sram_we_o,
  output logic [SelW-1:0]  sram_sel_o,
  output logic [AddrW-1:0] sram_addr_o,
  output logic [DataW-1:0] sram_dat_o,
  input  logic [DataW-1:0] sram_dat_i,
  input  logic             sram_ack_i,
  output logic             timeout_o
);

  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT_CYCLES);

  arb_state_e       r_state;
  req_id_e          r_last_grant;
  logic [WaitW-1:0] r_wait;
  logic             r_timeout;

  logic             w_cpu_req;
  logic             w_host_req;
  logic             w_gnt_cyc;
  req_id_e          w_gnt_id;
  logic [WaitW-1:0] w_wait_inc;

  assign w_cpu_req  = cpu_cyc_i & cpu_stb_i;
  assign w_host_req = host_cyc_i & host_stb_i;
  assign w_wait_inc = r_wait + 8'd1;

  // Arbitration FSM, round-robin record, wait counter and sticky timeout flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_last_grant <= ReqHost;
      r_wait       <= '0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_wait <= '0;
          // CPU wins when alone, or on contention if the host held the last grant.
          if (w_cpu_req && (!w_host_req || (r_last_grant == ReqHost))) begin
            r_state <= StGntCpu;
          end else if (w_host_req) begin
            r_state <= StGntHost;
          end
        end
        StGntCpu, StGntHost: begin
          // Ack beats timeout; abandoning the cycle releases without blame.
          if (sram_ack_i) begin
            r_state      <= StIdle;
            r_last_grant <= w_gnt_id;
          end else if (!w_gnt_cyc) begin
            r_state <= StIdle;
          end else if (w_wait_inc == TimeoutVal) begin
            r_state      <= StIdle;
            r_last_grant <= w_gnt_id;
            r_timeout    <= 1'b1;
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Request mux and ack steering; everything is zero outside a grant.
  always_comb begin
    w_gnt_id    = ReqCpu;
    w_gnt_cyc   = 1'b0;
    sram_cyc_o  = 1'b0;
    sram_stb_o  = 1'b0;
    sram_we_o   = 1'b0;
    sram_sel_o  = '0;
    sram_addr_o = '0;
    sram_dat_o  = '0;
    cpu_ack_o   = 1'b0;
    host_ack_o  = 1'b0;
    case (r_state)
      StGntCpu: begin
        w_gnt_id    = ReqCpu;
        w_gnt_cyc   = cpu_cyc_i;
        sram_cyc_o  = w_cpu_req;
        sram_stb_o  = w_cpu_req;
        sram_we_o   = cpu_we_i;
        sram_sel_o  = cpu_sel_i;
        sram_addr_o = cpu_addr_i;
        sram_dat_o  = cpu_dat_i;
        cpu_ack_o   = sram_ack_i;
      end
      StGntHost: begin
        w_gnt_id    = ReqHost;
        w_gnt_cyc   = host_cyc_i;
        sram_cyc_o  = w_host_req;
        sram_stb_o  = w_host_req;
        sram_we_o   = host_we_i;
        sram_sel_o  = host_sel_i;
        sram_addr_o = host_addr_i;
        sram_dat_o  = host_dat_i;
        host_ack_o  = sram_ack_i;
      end
      default: ;
    endcase
  end

  assign rd_dat_o  = sram_dat_i;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_spell_sram_arbiter.sv
// Scoreboard bench for spell_sram_arbiter (TIMEOUT_CYCLES=4). Stimulus pushes the
// expected transaction for each request; a negedge monitor pops one entry per
// ack pulse and compares routing, address, control and data.
module tb_spell_sram_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic [7:0]  cpu_addr_i;
  logic [31:0] cpu_dat_i;
  logic        cpu_ack_o;
  logic        host_cyc_i, host_stb_i, host_we_i;
  logic [3:0]  host_sel_i;
  logic [7:0]  host_addr_i;
  logic [31:0] host_dat_i;
  logic        host_ack_o;
  logic [31:0] rd_dat_o;
  logic        sram_cyc_o, sram_stb_o, sram_we_o;
  logic [3:0]  sram_sel_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_dat_o;
  logic [31:0] sram_dat_i;
  logic        sram_ack_i;
  logic        timeout_o;

  spell_sram_arbiter #(.TIMEOUT_CYCLES(4)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_cyc_i   (cpu_cyc_i),
    .cpu_stb_i   (cpu_stb_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_sel_i   (cpu_sel_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_dat_i   (cpu_dat_i),
    .cpu_ack_o   (cpu_ack_o),
    .host_cyc_i  (host_cyc_i),
    .host_stb_i  (host_stb_i),
    .host_we_i   (host_we_i),
    .host_sel_i  (host_sel_i),
    .host_addr_i (host_addr_i),
    .host_dat_i  (host_dat_i),
    .host_ack_o  (host_ack_o),
    .rd_dat_o    (rd_dat_o),
    .sram_cyc_o  (sram_cyc_o),
    .sram_stb_o  (sram_stb_o),
    .sram_we_o   (sram_we_o),
    .sram_sel_o  (sram_sel_o),
    .sram_addr_o (sram_addr_o),
    .sram_dat_o  (sram_dat_o),
    .sram_dat_i  (sram_dat_i),
    .sram_ack_i  (sram_ack_i),
    .timeout_o   (timeout_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple SRAM: acks one cycle after it sees stb (when enabled); byte-lane writes.
  bit   [31:0] mem [256];
  logic        model_ack;
  logic        force_ack;
  logic        ack_en;

  assign sram_ack_i = model_ack | force_ack;
  assign sram_dat_i = mem[sram_addr_o];

  always @(posedge clock or posedge reset) begin
    if (reset)          model_ack <= 1'b0;
    else if (model_ack) model_ack <= 1'b0;
    else if (ack_en && sram_stb_o) model_ack <= 1'b1;
  end

  always @(posedge clock) begin
    if (reset) begin
      mem[8'h12] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hC0FFEE00;
      mem[8'h30] <= 32'h0BADF00D;
      mem[8'h47] <= 32'h00000000;
    end else if (model_ack && sram_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_sel_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_dat_o[8*b +: 8];
      end
    end
  end

  typedef struct {
    bit          is_host;
    bit          we;
    logic [3:0]  sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per ack pulse.
  always @(negedge clock) begin
    if (!reset && (cpu_ack_o || host_ack_o)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=cpu%0b_host%0b required=no_ack",
                 cpu_ack_o, host_ack_o);
      end else begin
        mon_e = sb.pop_front();
        check("ack_both", 32'(cpu_ack_o & host_ack_o), 32'd0);
        check("ack_who", 32'(host_ack_o), 32'(mon_e.is_host));
        check("sram_addr", 32'(sram_addr_o), 32'(mon_e.addr));
        check("sram_we", 32'(sram_we_o), 32'(mon_e.we));
        check("sram_sel", 32'(sram_sel_o), 32'(mon_e.sel));
        if (mon_e.we) check("sram_wdat", sram_dat_o, mon_e.data);
        else          check("rd_dat", rd_dat_o, mon_e.data);
      end
    end
  end

  task automatic set_cpu(input logic we, input logic [3:0] sel, input logic [7:0] addr,
                         input logic [31:0] dat);
    cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = addr; cpu_dat_i = dat;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
  endtask

  task automatic set_host(input logic we, input logic [3:0] sel, input logic [7:0] addr,
                          input logic [31:0] dat);
    host_we_i = we; host_sel_i = sel; host_addr_i = addr; host_dat_i = dat;
    host_cyc_i = 1'b1; host_stb_i = 1'b1;
  endtask

  task automatic push(input bit is_host, input bit we, input logic [3:0] sel,
                      input logic [7:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_host = is_host; e.we = we; e.sel = sel; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Returns at the negedge of the n-th ack pulse, or after the cycle budget.
  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clock);
      if (cpu_ack_o || host_ack_o) seen++;
    end
    check("ack_count", 32'(seen), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0; cpu_sel_i = '0; cpu_addr_i = '0; cpu_dat_i = '0;
    host_cyc_i = 0; host_stb_i = 0; host_we_i = 0; host_sel_i = '0; host_addr_i = '0;
    host_dat_i = '0;
    ack_en = 1'b1;
    force_ack = 1'b0;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cyc", 32'(sram_cyc_o), 32'd0);
    check("rst_stb", 32'(sram_stb_o), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack_o), 32'd0);
    check("rst_host_ack", 32'(host_ack_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    reset = 1'b0;

    // Both requesting right after reset: CPU, host, CPU, host
    @(negedge clock);
    set_cpu(1'b0, 4'hF, 8'h20, 32'h0);
    set_host(1'b0, 4'hF, 8'h30, 32'h0);
    push(1'b0, 1'b0, 4'hF, 8'h20, 32'hC0FFEE00);
    push(1'b1, 1'b0, 4'hF, 8'h30, 32'h0BADF00D);
    push(1'b0, 1'b0, 4'hF, 8'h20, 32'hC0FFEE00);
    push(1'b1, 1'b0, 4'hF, 8'h30, 32'h0BADF00D);
    wait_acks(4, 40);
    cpu_cyc_i = 0; cpu_stb_i = 0; host_cyc_i = 0; host_stb_i = 0;

    // CPU-only read at 0x12
    @(negedge clock);
    set_cpu(1'b0, 4'hF, 8'h12, 32'h0);
    push(1'b0, 1'b0, 4'hF, 8'h12, 32'hDEADBEEF);
    wait_acks(1, 20);
    cpu_cyc_i = 0; cpu_stb_i = 0;

    // Host byte-lane write at 0x47
    @(negedge clock);
    set_host(1'b1, 4'b0100, 8'h47, 32'h01020304);
    push(1'b1, 1'b1, 4'b0100, 8'h47, 32'h01020304);
    wait_acks(1, 20);
    host_cyc_i = 0; host_stb_i = 0;

    // CPU readback: only byte 2 was written
    @(negedge clock);
    set_cpu(1'b0, 4'hF, 8'h47, 32'h0);
    push(1'b0, 1'b0, 4'hF, 8'h47, 32'h00020000);
    wait_acks(1, 20);
    cpu_cyc_i = 0; cpu_stb_i = 0;

    // Timeout: SRAM silent, host wins (CPU had last grant), released after 4 cycles
    @(negedge clock);
    ack_en = 1'b0;
    set_cpu(1'b0, 4'hF, 8'h20, 32'h0);
    set_host(1'b0, 4'hF, 8'h30, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("to_host_stb", 32'(sram_stb_o), 32'd1);
      check("to_host_addr", 32'(sram_addr_o), 32'h30);
      check("to_flag_low", 32'(timeout_o), 32'd0);
    end
    @(negedge clock);
    check("to_released", 32'(sram_stb_o), 32'd0);
    check("to_flag_set", 32'(timeout_o), 32'd1);
    @(negedge clock);
    check("to_cpu_stb", 32'(sram_stb_o), 32'd1);
    check("to_cpu_addr", 32'(sram_addr_o), 32'h20);
    host_cyc_i = 0; host_stb_i = 0;
    ack_en = 1'b1;
    push(1'b0, 1'b0, 4'hF, 8'h20, 32'hC0FFEE00);
    wait_acks(1, 20);
    cpu_cyc_i = 0; cpu_stb_i = 0;
    @(negedge clock);
    check("to_sticky", 32'(timeout_o), 32'd1);

    // Reset mid-grant, then a stray ack after release
    ack_en = 1'b0;
    set_cpu(1'b0, 4'hF, 8'h12, 32'h0);
    @(posedge clock);
    @(posedge clock);
    #3;
    check("mid_grant_stb", 32'(sram_stb_o), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_cyc", 32'(sram_cyc_o), 32'd0);
    check("arst_stb", 32'(sram_stb_o), 32'd0);
    check("arst_addr", 32'(sram_addr_o), 32'd0);
    check("arst_timeout", 32'(timeout_o), 32'd0);
    @(negedge clock);
    cpu_cyc_i = 0; cpu_stb_i = 0;
    reset = 1'b0;
    force_ack = 1'b1;
    #1;
    check("stray_cpu_ack", 32'(cpu_ack_o), 32'd0);
    check("stray_host_ack", 32'(host_ack_o), 32'd0);
    @(negedge clock);
    force_ack = 1'b0;
    check("post_rst_idle", 32'(sram_cyc_o), 32'd0);
    check("post_rst_timeout", 32'(timeout_o), 32'd0);

    @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
